// File: rtl/ioc_bus_ctrl_if.sv
// rtl/ioc_bus_ctrl_if.sv - host byte stream and module bus bundle for ioc_bus_ctrl
interface ioc_bus_ctrl_if;
    // Host serial side
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_frame;
    logic        i_err_clr;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_err;

    // Peripheral module side
    logic [31:0] i_mod_data;
    logic [3:0]  o_cs;
    logic [4:0]  o_ioc;
    logic [7:0]  o_data;
    logic        o_fetch_cmd;
    logic        o_load_cmd;

    // Driver of the host stream and module read-back data
    modport master (
        output i_rx_data, i_rx_valid, i_frame, i_err_clr, i_mod_data,
        input  o_tx_data, o_tx_valid, o_busy, o_err,
        input  o_cs, o_ioc, o_data, o_fetch_cmd, o_load_cmd
    );

    // The bus controller itself
    modport slave (
        input  i_rx_data, i_rx_valid, i_frame, i_err_clr, i_mod_data,
        output o_tx_data, o_tx_valid, o_busy, o_err,
        output o_cs, o_ioc, o_data, o_fetch_cmd, o_load_cmd
    );
endinterface

// File: rtl/ioc_bus_ctrl.sv
// rtl/ioc_bus_ctrl.sv - host opcode/data byte decoder driving module load/fetch strobes; optional wait timeout under IOC_BUS_CTRL_TIMEOUT_EN
module ioc_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           i_sys_clk,
    input  logic           i_rst,
    ioc_bus_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DATA  = 3'd1,
        ST_LOAD       = 3'd2,
        ST_FETCH      = 3'd3,
        ST_CAPTURE    = 3'd4,
        ST_WAIT_DUMMY = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mod_q,   mod_d;
    logic [4:0]  ioc_q,   ioc_d;
    logic [7:0]  data_q,  data_d;
    logic        err_q,   err_d;
    logic        err_set;
    logic        timeout_hit;

`ifdef IOC_BUS_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_wait;

    // Idle-wait counter: runs only while parked in a wait state, restarts on every state change
    always_comb begin
        in_wait     = (state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_DUMMY);
        timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d       = '0;
        if (in_wait && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    // Next-state decode of the host byte stream plus the sticky error flag
    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        ioc_d   = ioc_q;
        data_d  = data_q;
        err_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Bytes outside a frame are noise and are dropped here
                if (bus.i_frame && bus.i_rx_valid) begin
                    mod_d   = bus.i_rx_data[6:5];
                    ioc_d   = bus.i_rx_data[4:0];
                    state_d = bus.i_rx_data[7] ? ST_FETCH : ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else if (!bus.i_frame) begin
                    state_d = ST_IDLE;
                end else if (bus.i_rx_valid) begin
                    data_d  = bus.i_rx_data;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Strobe always completes; a byte arriving now has nowhere to go
                state_d = ST_IDLE;
                err_set = bus.i_rx_valid;
            end

            ST_FETCH: begin
                state_d = ST_CAPTURE;
                err_set = bus.i_rx_valid;
            end

            ST_CAPTURE: begin
                state_d = bus.i_frame ? ST_WAIT_DUMMY : ST_IDLE;
                err_set = bus.i_rx_valid;
            end

            ST_WAIT_DUMMY: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else if (!bus.i_frame || bus.i_rx_valid) begin
                    // The dummy byte only clocks the response out on the host side
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error in the same cycle as a clear request wins
        err_d = err_q;
        if (bus.i_err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // State, decoded fields and error flag registers
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mod_q   <= '0;
            ioc_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            ioc_q   <= ioc_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Output decode: strobes and chip select exist only in LOAD/FETCH, response only in CAPTURE
    always_comb begin
        bus.o_cs        = 4'b0000;
        bus.o_fetch_cmd = 1'b0;
        bus.o_load_cmd  = 1'b0;
        bus.o_tx_data   = 8'h00;
        bus.o_tx_valid  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                bus.o_cs       = 4'b0001 << mod_q;
                bus.o_load_cmd = 1'b1;
            end
            ST_FETCH: begin
                bus.o_cs        = 4'b0001 << mod_q;
                bus.o_fetch_cmd = 1'b1;
            end
            ST_CAPTURE: begin
                // A frame dropped during capture kills the response byte
                if (bus.i_frame) begin
                    bus.o_tx_data  = bus.i_mod_data[{mod_q, 3'b000} +: 8];
                    bus.o_tx_valid = 1'b1;
                end
            end
            default: begin
            end
        endcase

        bus.o_busy  = (state_q != ST_IDLE);
        bus.o_ioc   = ioc_q;
        bus.o_data  = data_q;
        bus.o_err   = err_q;
    end

endmodule

// File: tb/tb_ioc_bus_ctrl.sv
// tb/tb_ioc_bus_ctrl.sv - randomized self-checking bench for ioc_bus_ctrl
module tb_ioc_bus_ctrl;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    ioc_bus_ctrl_if bus ();

    ioc_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference decode: chip select and read-back byte chosen by opcode bits 6:5
    function automatic logic [3:0] ref_cs(input logic [7:0] op);
        return 4'(1 << op[6:5]);
    endfunction

    function automatic logic [7:0] ref_slice(input logic [31:0] md, input logic [7:0] op);
        logic [31:0] t;
        t = md >> (8 * op[6:5]);
        return t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cs"},    32'(bus.o_cs),        32'h0);
        check({tag, "_load"},  32'(bus.o_load_cmd),  32'h0);
        check({tag, "_fetch"}, 32'(bus.o_fetch_cmd), 32'h0);
        check({tag, "_txv"},   32'(bus.o_tx_valid),  32'h0);
    endtask

    logic [7:0]  op, d;
    logic [31:0] md;
    int          kind, w;

    initial begin
        rst            = 1'b1;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_frame    = 1'b0;
        bus.i_err_clr  = 1'b0;
        bus.i_mod_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_quiet("rst");
        check("rst_ioc",  32'(bus.o_ioc),     32'h0);
        check("rst_data", 32'(bus.o_data),    32'h0);
        check("rst_txd",  32'(bus.o_tx_data), 32'h0);
        check("rst_busy", 32'(bus.o_busy),    32'h0);
        check("rst_err",  32'(bus.o_err),     32'h0);

        // Byte outside a frame is ignored
        send(8'hA5);
        check("noframe_busy", 32'(bus.o_busy), 32'h0);

        // Write 0x25, 0xA5
        bus.i_frame = 1'b1;
        op = 8'h25;
        send(op);
        check("wr_wait_busy", 32'(bus.o_busy), 32'h1);
        check_quiet("wr_wait");
        send(8'hA5);
        check("wr_load",  32'(bus.o_load_cmd), 32'h1);
        check("wr_cs",    32'(bus.o_cs),       32'(ref_cs(op)));
        check("wr_ioc",   32'(bus.o_ioc),      32'h05);
        check("wr_data",  32'(bus.o_data),     32'hA5);
        tick();
        check_quiet("wr_after");
        check("wr_after_busy", 32'(bus.o_busy), 32'h0);
        check("wr_hold_data",  32'(bus.o_data), 32'hA5);

        // Read 0xC1 with 0x3C in the addressed slice
        op = 8'hC1;
        md = 32'h11223344;
        md[8*op[6:5] +: 8] = 8'h3C;
        bus.i_mod_data = md;
        send(op);
        check("rd_fetch", 32'(bus.o_fetch_cmd), 32'h1);
        check("rd_cs",    32'(bus.o_cs),        32'(ref_cs(op)));
        check("rd_ioc",   32'(bus.o_ioc),       32'h01);
        check("rd_txv0",  32'(bus.o_tx_valid),  32'h0);
        tick();
        check("rd_txv",   32'(bus.o_tx_valid),  32'h1);
        check("rd_txd",   32'(bus.o_tx_data),   32'h3C);
        check("rd_cap_cs", 32'(bus.o_cs),       32'h0);
        tick();
        check("rd_dummy_busy", 32'(bus.o_busy), 32'h1);
        check_quiet("rd_dummy");
        send(8'h00);
        check("rd_idle",  32'(bus.o_busy),      32'h0);
        check("rd_hold_data", 32'(bus.o_data),  32'hA5);

        // Abort after write opcode
        send(8'h25);
        bus.i_frame = 1'b0;
        tick();
        check("abort_busy", 32'(bus.o_busy), 32'h0);
        check("abort_err",  32'(bus.o_err),  32'h0);
        for (int i = 0; i < 3; i++) begin
            check("abort_noload", 32'(bus.o_load_cmd), 32'h0);
            tick();
        end
        bus.i_frame = 1'b1;

        // Overrun during FETCH; the read still completes
        op = 8'hE7;
        send(op);
        send(8'h77);
        check("ovr_err",  32'(bus.o_err),      32'h1);
        check("ovr_txv",  32'(bus.o_tx_valid), 32'h1);
        check("ovr_txd",  32'(bus.o_tx_data),  32'(ref_slice(md, op)));
        tick();
        send(8'h00);
        check("ovr_idle", 32'(bus.o_busy),     32'h0);
        check("ovr_sticky", 32'(bus.o_err),    32'h1);
        bus.i_err_clr = 1'b1;
        tick();
        bus.i_err_clr = 1'b0;
        check("errclr", 32'(bus.o_err), 32'h0);

        // Overrun and clear in the same cycle: error wins
        send(8'h80);
        bus.i_err_clr = 1'b1;
        send(8'h55);
        bus.i_err_clr = 1'b0;
        check("prio_err", 32'(bus.o_err), 32'h1);
        tick();
        send(8'h00);
        bus.i_err_clr = 1'b1;
        tick();
        bus.i_err_clr = 1'b0;
        check("prio_clr", 32'(bus.o_err), 32'h0);

`ifdef IOC_BUS_CTRL_TIMEOUT_EN
        // Timeout after eight cycles in WAIT_DATA
        send(8'h25);
        for (int i = 0; i < 7; i++) begin
            check("to_wait_busy", 32'(bus.o_busy), 32'h1);
            tick();
        end
        check("to_wait_last", 32'(bus.o_busy), 32'h1);
        tick();
        check("to_idle", 32'(bus.o_busy), 32'h0);
        check("to_err",  32'(bus.o_err),  32'h1);
        check("to_noload", 32'(bus.o_load_cmd), 32'h0);
`else
        // Without the timeout the controller waits indefinitely
        send(8'h25);
        repeat (100) tick();
        check("nto_busy", 32'(bus.o_busy), 32'h1);
        check("nto_err",  32'(bus.o_err),  32'h0);
        send(8'h66);
        check("nto_load", 32'(bus.o_load_cmd), 32'h1);
        check("nto_data", 32'(bus.o_data),     32'h66);
        tick();
`endif
        bus.i_err_clr = 1'b1;
        tick();
        bus.i_err_clr = 1'b0;

        // Reset in WAIT_DATA, then a fresh write
        send(8'h25);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("rstw");
        check("rstw_ioc",  32'(bus.o_ioc),  32'h0);
        check("rstw_data", 32'(bus.o_data), 32'h0);
        check("rstw_busy", 32'(bus.o_busy), 32'h0);
        check("rstw_err",  32'(bus.o_err),  32'h0);
        op = 8'h25;
        send(op);
        send(8'h11);
        check("rstw_load", 32'(bus.o_load_cmd), 32'h1);
        check("rstw_cs",   32'(bus.o_cs),       32'(ref_cs(op)));
        check("rstw_ioc2", 32'(bus.o_ioc),      32'h05);
        check("rstw_d2",   32'(bus.o_data),     32'h11);
        tick();

        // Randomized back-to-back transactions within one frame
        for (int n = 0; n < 150; n++) begin
            kind  = int'($urandom_range(0, 3));
            op    = 8'($urandom);
            op[7] = (kind == 1) || (kind == 3);
            d     = 8'($urandom);
            md    = $urandom;
            bus.i_mod_data = md;
            repeat ($urandom_range(0, 2)) tick();
            case (kind)
                0: begin
                    send(op);
                    w = int'($urandom_range(0, 3));
                    for (int i = 0; i < w; i++) begin
                        check("r_wr_wait", 32'(bus.o_load_cmd), 32'h0);
                        tick();
                    end
                    send(d);
                    check("r_wr_load", 32'(bus.o_load_cmd), 32'h1);
                    check("r_wr_cs",   32'(bus.o_cs),       32'(ref_cs(op)));
                    check("r_wr_ioc",  32'(bus.o_ioc),      32'(op[4:0]));
                    check("r_wr_data", 32'(bus.o_data),     32'(d));
                    tick();
                    check("r_wr_end",  32'(bus.o_busy),     32'h0);
                    check("r_wr_hold", 32'(bus.o_data),     32'(d));
                end
                1: begin
                    send(op);
                    check("r_rd_fetch", 32'(bus.o_fetch_cmd), 32'h1);
                    check("r_rd_cs",    32'(bus.o_cs),        32'(ref_cs(op)));
                    check("r_rd_ioc",   32'(bus.o_ioc),       32'(op[4:0]));
                    tick();
                    check("r_rd_txv",   32'(bus.o_tx_valid),  32'h1);
                    check("r_rd_txd",   32'(bus.o_tx_data),   32'(ref_slice(md, op)));
                    tick();
                    w = int'($urandom_range(0, 3));
                    for (int i = 0; i < w; i++) begin
                        check("r_rd_dummy", 32'(bus.o_busy), 32'h1);
                        tick();
                    end
                    send(d);
                    check("r_rd_end",   32'(bus.o_busy),      32'h0);
                end
                2: begin
                    send(op);
                    bus.i_frame = 1'b0;
                    tick();
                    check("r_ab_busy", 32'(bus.o_busy),     32'h0);
                    check("r_ab_load", 32'(bus.o_load_cmd), 32'h0);
                    bus.i_frame = 1'b1;
                end
                default: begin
                    send(op);
                    bus.i_frame = 1'b0;
                    check("r_abr_fetch", 32'(bus.o_fetch_cmd), 32'h1);
                    tick();
                    check("r_abr_txv",   32'(bus.o_tx_valid),  32'h0);
                    tick();
                    check("r_abr_busy",  32'(bus.o_busy),      32'h0);
                    bus.i_frame = 1'b1;
                end
            endcase
            check("r_err", 32'(bus.o_err), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
